muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//   Sequencer for the multi-cycle MULT and DIV units and the shared Hi/Lo registers.
//   The main control unit issues a single-cycle request and waits for done or div0_excpt.
//   Meanwhile this block:
//     - runs the selected unit for a fixed cycle count,
//     - steers the Hi/Lo input muxes,
//     - pulses the Hi/Lo write enables once,
//     - raises a divide-by-zero exception instead of running DIV when the divisor is 0.
// PARAMETERS
//   MULT_CYCLES  32  cycles mult_ctrl is held high per MULT (>=1)
//   DIV_CYCLES   32  cycles div_run is held high per DIV (>=1)
//   CNT_W        6   counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1
// PORTS
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-low reset
//   mult_req     in   1  start MULT; sampled only in IDLE
//   div_req      in   1  start DIV; sampled only in IDLE
//   divisor_zero in   1  B operand == 0; sampled with div_req in IDLE
//   busy         out  1  1 whenever state != IDLE
//   done         out  1  1-cycle pulse, asserted in WB
//   div0_excpt   out  1  1-cycle pulse, asserted in EXC
//   mult_ctrl    out  1  drives the mult unit; high throughout MRUN
//   div_a_write  out  1  div operand-A load; high in DLOAD only
//   div_b_write  out  1  div operand-B load; high in DLOAD only
//   div_run      out  1  div unit iterate enable; high throughout DRUN
//   md_select    out  1  Hi/Lo mux select: 1 = mult result, 0 = div result
//   hi_write     out  1  Hi register write enable; high in WB only
//   lo_write     out  1  Lo register write enable; high in WB only
// BEHAVIOUR
//   States: IDLE, MRUN, DLOAD, DRUN, WB, EXC. State, counter and op flag are registered.
//   All outputs are Moore decodes of the state, except md_select, which is the registered op flag.
//   Reset (reset==0, asynchronous):
//     - state=IDLE, counter=0, op flag=0
//     - every output 0
//   Transitions from IDLE (mult_req has priority if both requests are high):
//     - mult_req                  -> MRUN, cnt=MULT_CYCLES-1, op=1
//     - div_req & !divisor_zero   -> DLOAD, op=0
//     - div_req & divisor_zero    -> EXC, op unchanged
//   Transitions from the other states:
//     - DLOAD -> DRUN, cnt=DIV_CYCLES-1
//     - MRUN/DRUN: cnt-- each cycle; when cnt==0 -> WB (no wrap, the counter never underflows)
//     - WB  -> IDLE; hi_write=lo_write=done=1 for exactly this cycle
//     - EXC -> IDLE; div0_excpt=1 for exactly this cycle; no Hi/Lo write, no done
//   Latency (request cycle = cycle 0):
//     - MULT: MRUN in cycles 1..MULT_CYCLES, WB in cycle MULT_CYCLES+1
//     - DIV: DLOAD in cycle 1, DRUN in cycles 2..DIV_CYCLES+1, WB in cycle DIV_CYCLES+2
//     - DIV by zero: EXC in cycle 1
//   Requests are ignored while busy=1; they are not queued.
//   A new request may be accepted in the cycle after WB or EXC, once the state is back in IDLE.
//   md_select is stable from the accept edge through WB, so the Hi/Lo muxes never glitch mid-write.
//   Reset asserted mid-operation aborts immediately to IDLE:
//     - hi_write/lo_write are guaranteed never to pulse for the aborted op
//     - mult/div unit contents are don't-care
//   divisor_zero is ignored outside the IDLE accept cycle.
// TESTING
//   1. Reset: release reset, idle 3 cycles -> all outputs 0, busy=0.
//   2. MULT, defaults: mult_req at cycle 0 ->
//      - mult_ctrl high in cycles 1..32
//      - WB at cycle 33: hi_write=lo_write=done=1, md_select=1
//      - busy=0 at cycle 34
//   3. DIV, divisor 7: div_req at cycle 0 ->
//      - div_a_write=div_b_write=1 at cycle 1
//      - div_run high in cycles 2..33
//      - done at cycle 34 with md_select=0
//   4. DIV, divisor 0: div_req=1, divisor_zero=1 ->
//      - div0_excpt=1 in cycle 1 only
//      - no hi_write, lo_write or done; busy=0 at cycle 2
//   5. Simultaneous requests, then a request while busy:
//      - mult_req=div_req=1 in cycle 0 -> MULT path only, md_select=1
//      - div_req pulsed in cycle 10 -> ignored; the op still completes at cycle 33
//   6. Reset mid-op:
//      - reset low at cycle 15 of a DIV -> all outputs 0 asynchronously
//      - release and idle 40 cycles -> no hi_write observed
//      - MULT_CYCLES=1 variant: WB at cycle 2

Source files
------------

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequencer for the multi-cycle MULT/DIV units and shared Hi/Lo write-back
module muldiv_seq #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic mult_req,
    input  logic div_req,
    input  logic divisor_zero,
    output logic busy,
    output logic done,
    output logic div0_excpt,
    output logic mult_ctrl,
    output logic div_a_write,
    output logic div_b_write,
    output logic div_run,
    output logic md_select,
    output logic hi_write,
    output logic lo_write
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MRUN  = 3'd1;
    localparam logic [2:0] DLOAD = 3'd2;
    localparam logic [2:0] DRUN  = 3'd3;
    localparam logic [2:0] WB    = 3'd4;
    localparam logic [2:0] EXC   = 3'd5;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op, op_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op;
        case (state)
            IDLE: begin
                if (mult_req) begin
                    state_nxt = MRUN;
                    cnt_nxt   = MULT_LAST;
                    op_nxt    = 1'b1;
                end else if (div_req) begin
                    // A zero divisor skips the divider entirely; op is left untouched.
                    if (divisor_zero) begin
                        state_nxt = EXC;
                    end else begin
                        state_nxt = DLOAD;
                        op_nxt    = 1'b0;
                    end
                end
            end
            DLOAD: begin
                state_nxt = DRUN;
                cnt_nxt   = DIV_LAST;
            end
            MRUN, DRUN: begin
                if (cnt == '0) begin
                    state_nxt = WB;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WB, EXC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op    <= op_nxt;
        end
    end

    // Hi/Lo mux select comes straight from the op flag so it holds across write-back.
    assign md_select   = op;
    assign busy        = (state != IDLE);
    assign done        = (state == WB);
    assign hi_write    = (state == WB);
    assign lo_write    = (state == WB);
    assign div0_excpt  = (state == EXC);
    assign mult_ctrl   = (state == MRUN);
    assign div_a_write = (state == DLOAD);
    assign div_b_write = (state == DLOAD);
    assign div_run     = (state == DRUN);

endmodule
